uart_packet_transmitter: RTL
============================

Name: uart_packet_transmitter

Overview:
- Transmit-side counterpart of the board's UART feedback/command receive path.
- Accepts typed packet requests from control logic (operate keys, script engine), packs them into one byte {payload[5:0], type[1:0]}, buffers them in a small FIFO, and serialises each byte as 8N1 UART on `tx`.
- Sits between the board control logic and the UART TX pin, in the `uart_clk` domain.

Parameters:
- CLKS_PER_BIT, 16, number of `uart_clk` cycles per UART bit period (>=2).
- FIFO_DEPTH, 4, packet buffer entries (power of two, >=2).

Ports:
- uart_clk  input  1  sole clock for the block.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  packet request is present this cycle.
- cmd_type  input  2  packet type code (see package constants).
- cmd_payload  input  6  packet payload; bits [3:0] carry {sig_machine, sig_processing, sig_hand, sig_front} for feedback packets.
- cmd_ready  output  1  high when the FIFO is not full; a push occurs on cmd_valid && cmd_ready.
- tx  output  1  UART serial output; idles high.
- tx_busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  number of buffered packets, excluding the frame in flight.
- overflow  output  1  sticky; set when cmd_valid arrives while the FIFO is full.

Behaviour:
- Reset (asynchronous, immediate): tx=1, cmd_ready=1, tx_busy=0, fifo_level=0, overflow=0, FSM=IDLE, baud counter=0, FIFO pointers=0.
- Reset asserted mid-frame aborts the frame: tx goes to 1 at once and all buffered packets are discarded.
- Packing: byte = {cmd_payload, cmd_type}, so type sits in bits [1:0] and payload in bits [7:2]. All type codes, including PKT_NULL, are transmitted unmodified.
- FIFO handshake:
  - cmd_ready = !full, computed from the registered level.
  - A push while full is dropped and sets overflow on the next edge.
  - A push and a pop in the same cycle: the level is unchanged.
  - When full, a push is still rejected even if a pop occurs in that same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register, clear the bit index, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit. Eight bits, LSB first; after bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap between frames); otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1, resets on every state entry, and advances the bit on the terminal count.
- Latency: a push accepted on edge N makes the FIFO non-empty after N. The pop occurs on edge N+1, and tx falls low from edge N+1.
- Frame length: exactly 10*CLKS_PER_BIT cycles.
- tx is driven from a register (glitch-free).
- tx_busy = (state != IDLE) || (fifo_level != 0).

Decomposition:
- Shared package uart_pkt_pkg holds:
  - Type codes: PKT_NULL=2'b00, PKT_OPERATE=2'b01, PKT_FEEDBACK=2'b10, PKT_SCRIPT=2'b11. The same constants are used by the receive side's FEEDBACK decode.
  - Frame constants: DATA_BITS=8, START_BIT=1'b0, STOP_BIT=1'b1.
- One sub-module, pkt_fifo: a synchronous FIFO with push/pop/full/empty/level, parameterised by width 8 and FIFO_DEPTH.
- The serialiser FSM stays in the top module.

Test Plan:
1. Single packet (CLKS_PER_BIT=4): push type=2'b10, payload=6'b000101 (byte 0x16) -> tx samples at bit centres read 0, 0,1,1,0,1,0,0,0, 1. The frame lasts 40 cycles and tx_busy deasserts after the stop bit.
2. Back-to-back: push 0x01, 0x02, 0x03 on consecutive cycles -> three contiguous frames with no idle cycles between them. fifo_level sequence is 1,2 then drains to 0, and overflow stays 0.
3. Overflow: with a frame in flight, push 5 packets while FIFO_DEPTH=4 -> the first 4 are accepted, cmd_ready=0 on the fifth, overflow=1 and stays high. Only the 4 accepted bytes plus the in-flight byte appear on tx.
4. Full with simultaneous pop: FIFO full, cmd_valid held high on the STOP->START pop cycle -> that push is rejected and overflow sets. The push is accepted on the following cycle, and fifo_level returns to 4.
5. Reset mid-frame: assert rst during DATA bit 3 -> tx=1 within the same cycle and fifo_level=0. After release, no residual frame is transmitted, and a new push of 0xFF transmits correctly.
6. Type passthrough: send all four cmd_type codes with payload 6'h3F -> decoded bytes are 0xFC, 0xFD, 0xFE, 0xFF, in order.

Source files
------------

// File: rtl/uart_packet_transmitter_pkg.sv
// Shared packet/frame constants for the UART packet link (TX and RX sides).
// Type codes occupy byte bits [1:0]; payload occupies bits [7:2].
package uart_pkt_pkg;

   typedef enum logic [1:0] {
      PKT_NULL     = 2'b00,
      PKT_OPERATE  = 2'b01,
      PKT_FEEDBACK = 2'b10,
      PKT_SCRIPT   = 2'b11
   } pkt_type_e;

   localparam int   DATA_BITS = 8;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } tx_state_e;

   function automatic logic [7:0] pack_pkt(input logic [1:0] pkt_type, input logic [5:0] payload);
      return {payload, pkt_type};
   endfunction

endpackage

// File: rtl/uart_packet_transmitter_if.sv
// Command/status bundle between board control logic and the UART packet transmitter.
// master = control logic (request side), slave = transmitter.
interface uart_packet_transmitter_if #(
   parameter int FIFO_DEPTH = 4
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic          cmd_valid;
   logic [1:0]    cmd_type;
   logic [5:0]    cmd_payload;
   logic          cmd_ready;
   logic          tx;
   logic          tx_busy;
   logic [LW-1:0] fifo_level;
   logic          overflow;

   modport master (
      output cmd_valid, cmd_type, cmd_payload,
      input  cmd_ready, tx, tx_busy, fifo_level, overflow
   );

   modport slave (
      input  cmd_valid, cmd_type, cmd_payload,
      output cmd_ready, tx, tx_busy, fifo_level, overflow
   );
endinterface

// File: rtl/uart_packet_transmitter_fifo.sv
// Synchronous first-word-fall-through FIFO; head is visible on o_pop_dat while non-empty.
// Push accepted only when not full (even with a same-cycle pop); pop ignored when empty.
module pkt_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_push_dat,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_pop_dat,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_full    = (r_level == LW'(DEPTH));
   assign o_empty   = (r_level == '0);
   assign o_level   = r_level;
   assign o_pop_dat = r_mem[r_rd_ptr];
   assign w_push_ok = i_push && !o_full;
   assign w_pop_ok  = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_push_dat;
      end
   end

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/uart_packet_transmitter.sv
// Packs typed commands into {payload,type} bytes, buffers them and sends 8N1 UART on tx.
// Push on edge N -> tx start bit from edge N+1; frames run back-to-back while buffered.
module uart_packet_transmitter #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                      uart_clk,
   input  logic                      rst,
   uart_packet_transmitter_if.slave  bus
);
   import uart_pkt_pkg::*;

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam int BW = $clog2(DATA_BITS);

   tx_state_e     r_state;
   logic [CW-1:0] r_baud;
   logic [BW-1:0] r_bit_idx;
   logic [7:0]    r_shift;
   logic          r_tx;
   logic          r_overflow;

   logic          w_baud_tc;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic [7:0]    w_head;
   logic [LW-1:0] w_level;

   pkt_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (uart_clk),
      .rst        (rst),
      .i_push     (bus.cmd_valid),
      .i_push_dat (pack_pkt(bus.cmd_type, bus.cmd_payload)),
      .i_pop      (w_pop),
      .o_pop_dat  (w_head),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_level    (w_level)
   );

   assign w_baud_tc = (r_baud == CW'(CLKS_PER_BIT - 1));

   // Pop in IDLE, or at the end of a stop bit so the next frame follows with no gap.
   assign w_pop = !w_empty &&
                  ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_baud_tc));

   always_ff @(posedge uart_clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_baud    <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_tx      <= STOP_BIT;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_baud <= '0;
               r_tx   <= STOP_BIT;
               if (!w_empty) begin
                  r_shift   <= w_head;
                  r_bit_idx <= '0;
                  r_tx      <= START_BIT;
                  r_state   <= ST_START;
               end
            end
            ST_START: begin
               if (w_baud_tc) begin
                  r_baud  <= '0;
                  r_tx    <= r_shift[0];
                  r_state <= ST_DATA;
               end else begin
                  r_baud <= r_baud + CW'(1);
               end
            end
            ST_DATA: begin
               if (w_baud_tc) begin
                  r_baud <= '0;
                  if (r_bit_idx == BW'(DATA_BITS - 1)) begin
                     r_tx    <= STOP_BIT;
                     r_state <= ST_STOP;
                  end else begin
                     r_shift   <= {1'b0, r_shift[7:1]};
                     r_tx      <= r_shift[1];
                     r_bit_idx <= r_bit_idx + BW'(1);
                  end
               end else begin
                  r_baud <= r_baud + CW'(1);
               end
            end
            ST_STOP: begin
               if (w_baud_tc) begin
                  r_baud <= '0;
                  if (!w_empty) begin
                     r_shift   <= w_head;
                     r_bit_idx <= '0;
                     r_tx      <= START_BIT;
                     r_state   <= ST_START;
                  end else begin
                     r_tx    <= STOP_BIT;
                     r_state <= ST_IDLE;
                  end
               end else begin
                  r_baud <= r_baud + CW'(1);
               end
            end
            default: begin
               r_baud  <= '0;
               r_tx    <= STOP_BIT;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge uart_clk or posedge rst) begin
      if (rst) begin
         r_overflow <= 1'b0;
      end else if (bus.cmd_valid && w_full) begin
         r_overflow <= 1'b1;
      end
   end

   assign bus.cmd_ready  = !w_full;
   assign bus.tx         = r_tx;
   assign bus.tx_busy    = (r_state != ST_IDLE) || (w_level != '0);
   assign bus.fifo_level = w_level;
   assign bus.overflow   = r_overflow;

endmodule
